// File: rtl/decade_chain_ctrl.sv
// decade_chain_ctrl: run/stop/preset sequencer for a chain of BCD decade stages.
// Optional macro DECADE_PRESCALE_EN: gate count steps with a PRESCALE-cycle tick.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start, halt, clr     front-panel controls (priority clr > load > halt > start)
//   load, load_bcd       preset load (ignored in RUN), digit 0 in [3:0]
//   target_bcd           stop value compared after each step
//   up                   count direction, sampled every step
//   bcd                  current count
//   tc, ovf              one-cycle pulses: target hit, full-chain wrap
//   busy, state          RUN indicator, FSM state (IDLE/RUN/PAUSE/DONE)
module decade_chain_ctrl #(
    parameter int DIGITS   = 2,
    parameter int PRESCALE = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                halt,
    input  logic                clr,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_bcd,
    input  logic [4*DIGITS-1:0] target_bcd,
    input  logic                up,
    output logic [4*DIGITS-1:0] bcd,
    output logic                tc,
    output logic                ovf,
    output logic                busy,
    output logic [1:0]          state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    state_e              state_q, state_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                tc_q, tc_d;
    logic                ovf_q, ovf_d;

    logic [4*DIGITS-1:0] step_val;
    logic [4*DIGITS-1:0] load_val;
    logic                chain;
    logic                step_wrap;
    logic                step_en;

    logic do_clr, do_load, do_halt, do_start, do_run;

    // Decoded per-cycle action; the terms are mutually exclusive.
    assign do_clr   = clr;
    assign do_load  = !clr && load && (state_q != S_RUN);
    assign do_halt  = !clr && halt && (state_q == S_RUN);
    assign do_start = !clr && !do_load && start && (state_q != S_RUN);
    assign do_run   = !clr && !halt && (state_q == S_RUN);

    // Ripple carry/borrow: a digit moves only while every lower digit wrapped.
    always_comb begin
        chain    = 1'b1;
        step_val = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (chain) begin
                if (up) begin
                    if (bcd_q[4*k+:4] == 4'd9) begin
                        step_val[4*k+:4] = 4'd0;
                    end else begin
                        step_val[4*k+:4] = bcd_q[4*k+:4] + 4'd1;
                        chain = 1'b0;
                    end
                end else begin
                    if (bcd_q[4*k+:4] == 4'd0) begin
                        step_val[4*k+:4] = 4'd9;
                    end else begin
                        step_val[4*k+:4] = bcd_q[4*k+:4] - 4'd1;
                        chain = 1'b0;
                    end
                end
            end
        end
        step_wrap = chain;
    end

    // Non-BCD preset digits are stored as zero.
    always_comb begin
        load_val = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (load_bcd[4*k+:4] <= 4'd9) begin
                load_val[4*k+:4] = load_bcd[4*k+:4];
            end
        end
    end

`ifdef DECADE_PRESCALE_EN
    localparam int TW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [TW-1:0] tick_q, tick_d;

    assign step_en = (tick_q == TW'(PRESCALE - 1));

    // Resuming from PAUSE keeps the partial tick count.
    always_comb begin
        tick_d = tick_q;
        if (do_clr || do_load ||
            (do_start && state_q != S_PAUSE)) begin
            tick_d = '0;
        end else if (do_run) begin
            tick_d = step_en ? '0 : tick_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end
`else
    logic unused_prescale;

    assign unused_prescale = (PRESCALE != 0);
    assign step_en         = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        tc_d    = 1'b0;
        ovf_d   = 1'b0;
        unique case (1'b1)
            do_clr: begin
                bcd_d   = '0;
                state_d = S_IDLE;
            end
            do_load: begin
                bcd_d = load_val;
                if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            do_halt: begin
                state_d = S_PAUSE;
            end
            do_start: begin
                state_d = S_RUN;
            end
            do_run: begin
                if (step_en) begin
                    bcd_d = step_val;
                    ovf_d = step_wrap;
                    // Invalid target digits can never equal a BCD result.
                    if (step_val == target_bcd) begin
                        state_d = S_DONE;
                        tc_d    = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bcd_q   <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bcd   = bcd_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;
    assign busy  = (state_q == S_RUN);
    assign state = state_q;

endmodule

// File: tb/tb_decade_chain_ctrl.sv
// tb_decade_chain_ctrl: directed bench for decade_chain_ctrl, DIGITS=2.
// Integer count model checked every cycle plus literal checkpoints.
module tb_decade_chain_ctrl;

    localparam int DIGITS = 2;
    localparam int MOD    = 100;
`ifdef DECADE_PRESCALE_EN
    localparam int PS = 4;
`else
    localparam int PS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       halt = 1'b0;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic       up = 1'b1;
    logic [7:0] load_bcd = 8'h00;
    logic [7:0] target_bcd = 8'hAA;
    logic [7:0] bcd;
    logic       tc, ovf, busy;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decade_chain_ctrl #(.DIGITS(DIGITS), .PRESCALE(PS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .halt       (halt),
        .clr        (clr),
        .load       (load),
        .load_bcd   (load_bcd),
        .target_bcd (target_bcd),
        .up         (up),
        .bcd        (bcd),
        .tc         (tc),
        .ovf        (ovf),
        .busy       (busy),
        .state      (state)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int load_int(logic [7:0] b);
        int lo, hi;
        lo = (b[3:0] > 4'd9) ? 0 : int'(b[3:0]);
        hi = (b[7:4] > 4'd9) ? 0 : int'(b[7:4]);
        return hi * 10 + lo;
    endfunction

    function automatic logic [7:0] to_bcd(int v);
        logic [3:0] h, l;
        h = 4'(v / 10);
        l = 4'(v % 10);
        return {h, l};
    endfunction

    // Model: count as an integer mod 100; state 0..3 = IDLE/RUN/PAUSE/DONE.
    int m_val = 0;
    int m_st = 0;
    int m_tick = 0;
    bit m_tc = 1'b0;
    bit m_ovf = 1'b0;
    bit do_step;
    bit t_ok;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_val = 0; m_st = 0; m_tick = 0; m_tc = 0; m_ovf = 0;
        end else begin
            m_tc = 0;
            m_ovf = 0;
            if (clr) begin
                m_val = 0; m_st = 0; m_tick = 0;
            end else if (load && m_st != 1) begin
                m_val = load_int(load_bcd);
                if (m_st == 3) m_st = 0;
                m_tick = 0;
            end else if (halt && m_st == 1) begin
                m_st = 2;
            end else if (start && m_st != 1) begin
                if (m_st != 2) m_tick = 0;
                m_st = 1;
            end else if (m_st == 1) begin
                do_step = 1;
`ifdef DECADE_PRESCALE_EN
                if (m_tick == PS - 1) m_tick = 0;
                else begin
                    m_tick = m_tick + 1;
                    do_step = 0;
                end
`endif
                if (do_step) begin
                    if (up) begin
                        if (m_val == MOD - 1) m_ovf = 1;
                        m_val = (m_val + 1) % MOD;
                    end else begin
                        if (m_val == 0) m_ovf = 1;
                        m_val = (m_val == 0) ? MOD - 1 : m_val - 1;
                    end
                    t_ok = (target_bcd[3:0] <= 4'd9) && (target_bcd[7:4] <= 4'd9);
                    if (t_ok && m_val == load_int(target_bcd)) begin
                        m_st = 3;
                        m_tc = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_bcd", 32'(bcd), 32'(to_bcd(m_val)));
            chk("m_state", 32'(state), 32'(m_st));
            chk("m_tc", 32'(tc), 32'(m_tc));
            chk("m_ovf", 32'(ovf), 32'(m_ovf));
            chk("m_busy", 32'(busy), 32'(m_st == 1));
        end
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_bcd", 32'(bcd), 32'h00);
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_tc", 32'(tc), 32'h0);
        cyc(2);
        rst_n = 1'b1;

`ifndef DECADE_PRESCALE_EN
        // count to 0x37, then async reset
        load_bcd = 8'h30; load = 1; cyc(1); load = 0;
        start = 1; cyc(1); start = 0;
        cyc(7);
        chk("mid_37", 32'(bcd), 32'h37);
        rst_n = 1'b0;
        #1;
        chk("arst_bcd", 32'(bcd), 32'h00);
        chk("arst_state", 32'(state), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        #1 rst_n = 1'b1;

        // up wrap
        load_bcd = 8'h98; target_bcd = 8'hAA; up = 1;
        load = 1; cyc(1); load = 0;
        start = 1; cyc(1); start = 0;
        cyc(1); chk("up_99", 32'(bcd), 32'h99);
        cyc(1); chk("up_00", 32'(bcd), 32'h00);
        chk("up_ovf", 32'(ovf), 32'h1);
        cyc(1); chk("up_01", 32'(bcd), 32'h01);
        chk("up_ovf_off", 32'(ovf), 32'h0);
        chk("up_state", 32'(state), 32'h1);

        // down borrow
        halt = 1; cyc(1); halt = 0;
        chk("halt_pause", 32'(state), 32'h2);
        load_bcd = 8'h10; up = 0; load = 1; cyc(1); load = 0;
        start = 1; cyc(1); start = 0;
        cyc(1); chk("dn_09", 32'(bcd), 32'h09);
        cyc(1); chk("dn_08", 32'(bcd), 32'h08);
        cyc(8); chk("dn_00", 32'(bcd), 32'h00);
        cyc(1); chk("dn_99", 32'(bcd), 32'h99);
        chk("dn_ovf", 32'(ovf), 32'h1);

        // stop at target
        halt = 1; cyc(1); halt = 0;
        up = 1; load_bcd = 8'h05; target_bcd = 8'h12;
        load = 1; cyc(1); load = 0;
        start = 1; cyc(1); start = 0;
        cyc(7);
        chk("tgt_bcd", 32'(bcd), 32'h12);
        chk("tgt_state", 32'(state), 32'h3);
        chk("tgt_tc", 32'(tc), 32'h1);
        cyc(1); chk("tgt_tc_off", 32'(tc), 32'h0);
        cyc(20);
        chk("tgt_hold", 32'(bcd), 32'h12);
        chk("tgt_hold_st", 32'(state), 32'h3);

        // halt vs target collision, then clr+load+start
        load_bcd = 8'h02; target_bcd = 8'h03;
        load = 1; cyc(1); load = 0;
        chk("done_load_idle", 32'(state), 32'h0);
        start = 1; cyc(1); start = 0;
        halt = 1; cyc(1); halt = 0;
        chk("col_bcd", 32'(bcd), 32'h02);
        chk("col_state", 32'(state), 32'h2);
        chk("col_tc", 32'(tc), 32'h0);
        clr = 1; load = 1; start = 1; load_bcd = 8'h55;
        cyc(1); clr = 0; load = 0; start = 0;
        chk("clr_bcd", 32'(bcd), 32'h00);
        chk("clr_state", 32'(state), 32'h0);

        // start at target: full revolution before stopping
        load_bcd = 8'h07; target_bcd = 8'h07;
        load = 1; cyc(1); load = 0;
        start = 1; cyc(1); start = 0;
        cyc(1); chk("rev_08", 32'(bcd), 32'h08);
        chk("rev_run", 32'(state), 32'h1);
        cyc(98); chk("rev_06", 32'(bcd), 32'h06);
        cyc(1); chk("rev_07", 32'(bcd), 32'h07);
        chk("rev_done", 32'(state), 32'h3);
        chk("rev_tc", 32'(tc), 32'h1);

        // resume from DONE, then invalid target free-runs
        start = 1; cyc(1); start = 0;
        cyc(1); chk("resume_08", 32'(bcd), 32'h08);
        target_bcd = 8'h9A;
        cyc(5);

        // halt in IDLE, invalid preset, load ignored in RUN
        clr = 1; cyc(1); clr = 0;
        halt = 1; cyc(1); halt = 0;
        chk("idle_halt", 32'(state), 32'h0);
        load_bcd = 8'hC7; load = 1; cyc(1); load = 0;
        chk("inv_load", 32'(bcd), 32'h07);
        start = 1; cyc(1); start = 0;
        load_bcd = 8'h50; load = 1; cyc(1); load = 0;
        chk("run_noload", 32'(bcd), 32'h08);
        cyc(3);
`else
        // invalid preset and prescale timing
        load_bcd = 8'hC7; load = 1; cyc(1); load = 0;
        chk("inv_load", 32'(bcd), 32'h07);
        target_bcd = 8'hAA; up = 1;
        start = 1; cyc(1); start = 0;
        cyc(3);
        chk("ps_hold", 32'(bcd), 32'h07);
        chk("ps_run", 32'(state), 32'h1);
        cyc(1); chk("ps_08", 32'(bcd), 32'h08);
        cyc(3); chk("ps_hold2", 32'(bcd), 32'h08);
        cyc(1); chk("ps_09", 32'(bcd), 32'h09);
        cyc(2);
        halt = 1; cyc(1); halt = 0;
        cyc(3);
        start = 1; cyc(1); start = 0;
        cyc(12);
        load_bcd = 8'h18; target_bcd = 8'h20;
        halt = 1; cyc(1); halt = 0;
        load = 1; cyc(1); load = 0;
        start = 1; cyc(1); start = 0;
        cyc(8);
        chk("ps_tgt", 32'(bcd), 32'h20);
        chk("ps_done", 32'(state), 32'h3);
        cyc(4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decade_chain_ctrl.md
Name: decade_chain_ctrl

Overview:
Run/stop/preset controller and sequencer for a cascade of DIGITS decade (mod-10, BCD) counter stages. Owns the per-digit enable and carry/borrow chain, supports up/down counting, preset load and stop-at-target. Sits between the lab front-panel controls (start/halt/clear) and the multi-digit BCD display/compare logic.

Parameters:
DIGITS, 2, number of cascaded decade stages (1..6); count bus is 4*DIGITS bits.
PRESCALE, 10, clock cycles per count step when DECADE_PRESCALE_EN is defined (2..1024); ignored otherwise.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level-sampled; enter/resume RUN
halt  in  1  level-sampled; RUN -> PAUSE
clr  in  1  synchronous clear of count and state
load  in  1  preset count from load_bcd (IDLE/PAUSE/DONE only)
load_bcd  in  4*DIGITS  preset value, digit 0 in bits [3:0]
target_bcd  in  4*DIGITS  stop value
up  in  1  1 = count up, 0 = count down; sampled every step
bcd  out  4*DIGITS  current count, BCD per digit
tc  out  1  one-cycle pulse: count reached target
ovf  out  1  one-cycle pulse: full-chain wrap (up: all-9 -> all-0; down: all-0 -> all-9)
busy  out  1  high in RUN
state  out  2  IDLE=00, RUN=01, PAUSE=10, DONE=11

Behaviour:
- Single clock domain; clock is clk, reset is rst_n, asynchronous and active-low. All state changes on rising clk edge; rst_n low forces immediately: bcd=0, state=IDLE, tc=0, ovf=0, busy=0, prescale counter=0.
- Control priority per cycle: clr > load > halt > start.
- clr (any state): bcd<=0, state<=IDLE, no step that cycle, tc/ovf low.
- load: accepted in IDLE, PAUSE, DONE; bcd<=load_bcd, state unchanged except DONE->IDLE. Any loaded digit >9 is stored as 0. Ignored in RUN.
- FSM: IDLE -start-> RUN; RUN -halt-> PAUSE; PAUSE -start-> RUN; RUN -(step result == target_bcd)-> DONE; DONE -start-> RUN (continues from current value); halt in IDLE/PAUSE/DONE: no effect.
- Latency: start sampled at edge n -> state=RUN after edge n; first step at edge n+1 (no prescale). Step occurs every RUN cycle not overridden by clr/halt.
- Step, up=1: digit0 +1, 9 wraps to 0; digit k increments iff all lower digits ==9. Up=0: digit0 -1, 0 wraps to 9; digit k decrements iff all lower digits ==0.
- ovf pulses in the cycle after the wrapping step (registered), independent of target.
- Target compare applies to the post-step value only; entering RUN with bcd==target does not stop—chain runs until value returns to target (10^DIGITS steps).
- On target hit: bcd=target, state=DONE, tc=1 for exactly one cycle; if same step also wraps, ovf and tc pulse together.
- halt and target hit on same edge: halt wins (state=PAUSE, step suppressed, no tc).
- target_bcd digits >9 never match; counter free-runs.
- rst_n asserted mid-RUN: immediate return to reset values; no tc/ovf emitted.

Optional Feature:
DECADE_PRESCALE_EN: defined -> internal tick counter 0..PRESCALE-1 runs only in RUN; step occurs when tick counter ==PRESCALE-1, then it wraps to 0. Counter clears on clr, load, start from IDLE/DONE, and reset; holds in PAUSE. First step PRESCALE cycles after entering RUN. Undefined -> no tick counter, step every RUN cycle, PRESCALE unused.

Test Plan:
- Reset mid-count: DIGITS=2, run to bcd=0x37, assert rst_n=0 -> bcd=0x00, state=00, busy=0 immediately (before next edge).
- Up wrap: load 0x98, target 0xAA (never matches), start, up=1 -> sequence 0x99, 0x00 (ovf one-cycle pulse), 0x01; state stays 01.
- Down borrow: load 0x10, up=0, start -> 0x09, 0x08; from 0x00 next step 0x99 with ovf pulse.
- Stop at target: load 0x05, target 0x12, start -> 7 steps later bcd=0x12, state=11, tc high one cycle; bcd holds for 20 further cycles.
- Halt/target collision and priority: target 0x03 from 0x02, assert halt on hitting edge -> bcd=0x02, state=10, tc=0; then clr+load+start together -> bcd=0x00, state=00.
- Invalid load and prescale (DECADE_PRESCALE_EN, PRESCALE=4): load 0xC7 -> bcd=0x07; start -> first step to 0x08 exactly 4 cycles after RUN entry, then every 4 cycles.
